// File: rtl/dbus_demux_1x2.sv
`default_nettype none
// dbus_demux_1x2: single-outstanding data-bus demux, port 0 = data RAM, port 1 = MMIO.
// Optional macro DBUS_TIMEOUT_EN adds an ISSUE/WAIT timeout that returns an error response.
module dbus_demux_1x2 #(
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter logic [31:0] MMIO_MASK = 32'hF000_0000,
  parameter logic [7:0]  TIMEOUT   = 8'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        p0_valid,
  input  logic        p0_ready,
  output logic        p0_we,
  output logic [31:0] p0_addr,
  output logic [31:0] p0_wdata,
  output logic [3:0]  p0_be,
  input  logic        p0_rvalid,
  input  logic [31:0] p0_rdata,
  output logic        p1_valid,
  input  logic        p1_ready,
  output logic        p1_we,
  output logic [31:0] p1_addr,
  output logic [31:0] p1_wdata,
  output logic [3:0]  p1_be,
  input  logic        p1_rvalid,
  input  logic [31:0] p1_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sel;
  logic        r_we;
  logic        w_sel;
  logic        w_accept;
  logic        w_ready;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_tmo;
  logic        w_issue_adv;
  logic        w_complete;
  logic        w_abort;

  assign w_sel     = ((req_addr & MMIO_MASK) == (MMIO_BASE & MMIO_MASK));
  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_ready && req_valid;

  // Only the latched target's handshakes matter; the other port is ignored.
  assign w_ready  = r_sel ? p1_ready  : p0_ready;
  assign w_rvalid = r_sel ? p1_rvalid : p0_rvalid;
  assign w_rdata  = r_sel ? p1_rdata  : p0_rdata;

  assign w_issue_adv = (r_state == S_ISSUE) && w_ready && !r_we;
  assign w_complete  = ((r_state == S_ISSUE) && w_ready && r_we) ||
                       ((r_state == S_WAIT) && w_rvalid);
  assign w_abort     = w_tmo && !w_complete && !w_issue_adv;

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= 8'd0;
    end else if (w_accept) begin
      r_tmo_cnt <= 8'd0;
    end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  // Fires in the TIMEOUT-th cycle spent in ISSUE+WAIT.
  assign w_tmo = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                 (r_tmo_cnt >= (TIMEOUT - 8'd1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT;
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_ISSUE;
      S_ISSUE: begin
        if (w_ready) begin
          w_state_next = r_we ? S_RESP : S_WAIT;
        end else if (w_tmo) begin
          w_state_next = S_RESP;
        end
      end
      S_WAIT:  if (w_rvalid || w_tmo) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel     <= 1'b0;
      r_we      <= 1'b0;
      p0_valid  <= 1'b0;
      p0_we     <= 1'b0;
      p0_addr   <= '0;
      p0_wdata  <= '0;
      p0_be     <= '0;
      p1_valid  <= 1'b0;
      p1_we     <= 1'b0;
      p1_addr   <= '0;
      p1_wdata  <= '0;
      p1_be     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (w_accept) begin
        r_sel    <= w_sel;
        r_we     <= req_we;
        p0_valid <= ~w_sel;
        p0_we    <= ~w_sel & req_we;
        p0_addr  <= w_sel ? '0 : req_addr;
        p0_wdata <= w_sel ? '0 : req_wdata;
        p0_be    <= w_sel ? '0 : req_be;
        p1_valid <= w_sel;
        p1_we    <= w_sel & req_we;
        p1_addr  <= w_sel ? req_addr  : '0;
        p1_wdata <= w_sel ? req_wdata : '0;
        p1_be    <= w_sel ? req_be    : '0;
      end
      if (w_issue_adv) begin
        p0_valid <= 1'b0;
        p1_valid <= 1'b0;
      end
      // Request fields are released once the transaction finishes or aborts.
      if (w_complete || w_abort) begin
        p0_valid <= 1'b0;
        p0_we    <= 1'b0;
        p0_addr  <= '0;
        p0_wdata <= '0;
        p0_be    <= '0;
        p1_valid <= 1'b0;
        p1_we    <= 1'b0;
        p1_addr  <= '0;
        p1_wdata <= '0;
        p1_be    <= '0;
      end
      if (w_complete) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= r_we ? 32'h0 : w_rdata;
      end else if (w_abort) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= 32'hDEAD_BEEF;
      end
    end
  end

endmodule
`default_nettype wire
